ssm_word_sched: RTL and testbench

SSM_WORD_SCHED -- requirements
Module: ssm_word_sched

---
 rtl/vdcm_ssm_pkg.sv | 20 ++
 rtl/ssm_word_fifo.sv | 73 +++++++
 rtl/ssm_word_sched.sv | 163 ++++++++++++++++
 tb/tb_ssm_word_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdcm_ssm_pkg.sv
// rtl/vdcm_ssm_pkg.sv - shared defaults, scheduler state type and sizing helper
package vdcm_ssm_pkg;

    localparam int NUM_SSM_DEF        = 4;
    localparam int MUX_WORD_W_DEF     = 128;
    localparam int SSM_FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INIT_FILL = 2'd1,
        RUN       = 2'd2,
        FLUSH     = 2'd3
    } ssm_sched_state_t;

    // Index width that stays legal (>= 1 bit) for single-entry ranges.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssm_word_fifo.sv
// rtl/ssm_word_fifo.sv - per-substream mux word FIFO with registered head
// Ports: clk, rst (sync, active-high), clear (drop contents), push/push_data,
//        pop, head (word at read pointer), count, avail (count != 0),
//        underflow (pop seen while empty, combinational, not during clear).
module ssm_word_fifo
    import vdcm_ssm_pkg::*;
#(
    parameter int W     = MUX_WORD_W_DEF,
    parameter int DEPTH = SSM_FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         avail,
    output logic                         underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // An empty pop is dropped so the count can never wrap below zero.
    assign do_pop    = pop && (cnt != '0);
    assign do_push   = push && (cnt < CNT_W'(DEPTH));
    assign underflow = pop && (cnt == '0) && !clear;
    assign head      = mem[rd_ptr];
    assign count     = cnt;
    assign avail     = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ssm_word_sched.sv
// rtl/ssm_word_sched.sv - distributes upstream mux words to substream FIFOs
// Ports: clk, rst (sync, active-high), slice_start/slice_end pulses,
//        src_valid/src_ready/src_data upstream handshake, ssm_rd_en pops,
//        ssm_avail/ssm_data per-substream heads, busy, err_underflow (sticky).
// Build option: SSM_WORD_SCHED_STATS_EN adds word_cnt, one 16-bit saturating
//        delivered-word counter per substream.
module ssm_word_sched
    import vdcm_ssm_pkg::*;
#(
    parameter int NUM_SSM    = NUM_SSM_DEF,
    parameter int MUX_WORD_W = MUX_WORD_W_DEF,
    parameter int FIFO_DEPTH = SSM_FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          slice_start,
    input  logic                          slice_end,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic [MUX_WORD_W-1:0]         src_data,
    input  logic [NUM_SSM-1:0]            ssm_rd_en,
    output logic [NUM_SSM-1:0]            ssm_avail,
    output logic [NUM_SSM*MUX_WORD_W-1:0] ssm_data,
    output logic                          busy,
    output logic [NUM_SSM-1:0]            err_underflow
`ifdef SSM_WORD_SCHED_STATS_EN
    ,
    output logic [NUM_SSM*16-1:0]         word_cnt
`endif
);

    localparam int IDX_W = ptr_w(NUM_SSM);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    ssm_sched_state_t              state;
    logic [IDX_W-1:0]              rr_ptr;
    logic [IDX_W-1:0]              fill_idx;
    logic [IDX_W-1:0]              run_tgt;
    logic [IDX_W-1:0]              tgt;
    logic                          run_found;
    logic                          xfer;
    logic                          start_ok;
    logic                          fifo_clear;
    logic [NUM_SSM-1:0]            room;
    logic [NUM_SSM-1:0]            push;
    logic [NUM_SSM-1:0]            uf;
    logic [NUM_SSM-1:0][CNT_W-1:0] cnt;

    // Round-robin search from rr_ptr over registered counts; a pop in this
    // cycle only shows up as room once the count register has updated.
    always_comb begin
        logic [IDX_W-1:0] idx;
        run_found = 1'b0;
        run_tgt   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SSM; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_SSM);
            if (!run_found && room[idx]) begin
                run_found = 1'b1;
                run_tgt   = idx;
            end
        end
    end

    assign tgt = (state == INIT_FILL) ? fill_idx : run_tgt;

    // Words arriving alongside slice_end or rst would be discarded anyway,
    // so they are left with the source instead of being consumed.
    assign src_ready  = !rst && !slice_end &&
                        ((state == INIT_FILL) || ((state == RUN) && run_found));
    assign xfer       = src_valid && src_ready;
    assign start_ok   = (state == IDLE) && slice_start && !slice_end;
    assign fifo_clear = (state == FLUSH);
    assign busy       = (state != IDLE);

    for (genvar i = 0; i < NUM_SSM; i++) begin : g_ssm
        assign room[i] = (cnt[i] < CNT_W'(FIFO_DEPTH));
        assign push[i] = xfer && (tgt == IDX_W'(i));

        ssm_word_fifo #(
            .W     (MUX_WORD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .clear     (fifo_clear),
            .push      (push[i]),
            .push_data (src_data),
            .pop       (ssm_rd_en[i]),
            .head      (ssm_data[i*MUX_WORD_W +: MUX_WORD_W]),
            .count     (cnt[i]),
            .avail     (ssm_avail[i]),
            .underflow (uf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            fill_idx <= '0;
        end else if (slice_end) begin
            state <= FLUSH;
        end else begin
            case (state)
                IDLE: begin
                    if (slice_start) begin
                        state    <= INIT_FILL;
                        fill_idx <= '0;
                    end
                end
                INIT_FILL: begin
                    if (xfer) begin
                        if (fill_idx == IDX_W'(NUM_SSM - 1)) begin
                            state <= RUN;
                        end else begin
                            fill_idx <= fill_idx + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        rr_ptr <= (run_tgt == IDX_W'(NUM_SSM - 1)) ? '0
                                                                     : run_tgt + IDX_W'(1);
                    end
                end
                FLUSH: begin
                    state    <= IDLE;
                    rr_ptr   <= '0;
                    fill_idx <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_underflow <= '0;
        end else begin
            err_underflow <= err_underflow | uf;
        end
    end

`ifdef SSM_WORD_SCHED_STATS_EN
    logic [NUM_SSM-1:0][15:0] wcnt;

    assign word_cnt = wcnt;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            wcnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SSM; i++) begin
                if (push[i] && (wcnt[i] != 16'hFFFF)) begin
                    wcnt[i] <= wcnt[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ssm_word_sched.sv
// tb/tb_ssm_word_sched.sv - scoreboard bench for ssm_word_sched
module tb_ssm_word_sched;

    localparam int N = 4;
    localparam int W = 128;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           slice_start;
    logic           slice_end;
    logic           src_valid;
    logic           src_ready;
    logic [W-1:0]   src_data;
    logic [N-1:0]   ssm_rd_en;
    logic [N-1:0]   ssm_avail;
    logic [N*W-1:0] ssm_data;
    logic           busy;
    logic [N-1:0]   err_underflow;
`ifdef SSM_WORD_SCHED_STATS_EN
    logic [N*16-1:0] word_cnt;
`endif

    always #5 clk = ~clk;

    ssm_word_sched #(
        .NUM_SSM    (N),
        .MUX_WORD_W (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .slice_start   (slice_start),
        .slice_end     (slice_end),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_data      (src_data),
        .ssm_rd_en     (ssm_rd_en),
        .ssm_avail     (ssm_avail),
        .ssm_data      (ssm_data),
        .busy          (busy),
        .err_underflow (err_underflow)
`ifdef SSM_WORD_SCHED_STATS_EN
        ,
        .word_cnt      (word_cnt)
`endif
    );

    typedef struct {
        int           ssm;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Offer one word and wait for it to be taken; the expected destination
    // is recorded for the monitor before the accepting edge.
    task automatic send(input logic [W-1:0] d, input int ssm, input string name,
                        input int exp_wait);
        int w;
        exp_t e;
        w         = 0;
        src_data  = d;
        src_valid = 1'b1;
        @(negedge clk);
        while (!src_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!src_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got src_ready=0 expected 1 within 20 cycles", name);
        end else begin
            e.ssm  = ssm;
            e.data = d;
            exp_q.push_back(e);
        end
        cyc();
        chk({name, "_wait"}, 32'(w), 32'(exp_wait));
    endtask

    // Monitor: every effective pop is compared with the oldest expected
    // word for that substream.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (ssm_rd_en[i] && ssm_avail[i]) begin
                    int pos;
                    pos = -1;
                    foreach (exp_q[j]) begin
                        if (pos < 0 && exp_q[j].ssm == i) pos = j;
                    end
                    checks++;
                    if (pos < 0) begin
                        errors++;
                        $display("FAIL pop_ssm%0d: got %0h expected no word", i,
                                 ssm_data[i*W +: W]);
                    end else begin
                        if (ssm_data[i*W +: W] !== exp_q[pos].data) begin
                            errors++;
                            $display("FAIL pop_ssm%0d: got %0h expected %0h", i,
                                     ssm_data[i*W +: W], exp_q[pos].data);
                        end
                        exp_q.delete(pos);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        slice_start = 1'b0;
        slice_end   = 1'b0;
        src_valid   = 1'b0;
        src_data    = '0;
        ssm_rd_en   = '0;
        cyc();
        cyc();
        at_neg();
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        chk("rst_avail", 32'(ssm_avail), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_data_zero", 32'(ssm_data != '0), 32'd0);
        cyc();
        rst = 1'b0;

        // Initial fill: one word per substream in order.
        slice_start = 1'b1;
        cyc();
        slice_start = 1'b0;
        send(W'(128'hA0), 0, "fill0", 0);
        send(W'(128'hA1), 1, "fill1", 0);
        send(W'(128'hA2), 2, "fill2", 0);
        send(W'(128'hA3), 3, "fill3", 0);
        src_valid = 1'b0;
        at_neg();
        chk("fill_avail", 32'(ssm_avail), 32'hF);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_run_ready", 32'(src_ready), 32'd1);
        cyc();

        // Round-robin from substream 0 until every FIFO is full.
        send(W'(128'hB0), 0, "rr0", 0);
        send(W'(128'hB1), 1, "rr1", 0);
        send(W'(128'hB2), 2, "rr2", 0);
        send(W'(128'hB3), 3, "rr3", 0);
        src_data = W'(128'hB4);
        at_neg();
        chk("rr_full_ready", 32'(src_ready), 32'd0);
        chk("rr_full_avail", 32'(ssm_avail), 32'hF);
        src_valid = 1'b0;
        cyc();

        // Substream 2 drains every cycle; all new words must land there.
        ssm_rd_en = 4'b0100;
        send(W'(128'hC0), 2, "bp0", 1);
        send(W'(128'hC1), 2, "bp1", 0);
        send(W'(128'hC2), 2, "bp2", 0);
        send(W'(128'hC3), 2, "bp3", 0);
        src_valid = 1'b0;
        cyc();
        ssm_rd_en = '0;
        at_neg();
        chk("bp_avail", 32'(ssm_avail), 32'hB);
        chk("bp_err", 32'(err_underflow), 32'd0);
        cyc();

        // Build counts {2,1,2,0}, then collide slice_end with slice_start.
        send(W'(128'hD0), 2, "col_d0", 0);
        send(W'(128'hD1), 2, "col_d1", 0);
        src_valid = 1'b0;
        ssm_rd_en = 4'b1010;
        cyc();
        ssm_rd_en = 4'b1000;
        cyc();
        ssm_rd_en = '0;
        at_neg();
        chk("col_pre_avail", 32'(ssm_avail), 32'h7);
        cyc();
        slice_end   = 1'b1;
        slice_start = 1'b1;
        src_valid   = 1'b1;
        src_data    = W'(128'hE0);
        at_neg();
        chk("col_end_ready", 32'(src_ready), 32'd0);
        cyc();
        slice_end   = 1'b0;
        slice_start = 1'b0;
        exp_q.delete();
        at_neg();
        chk("col_flush_busy", 32'(busy), 32'd1);
        chk("col_flush_ready", 32'(src_ready), 32'd0);
        cyc();
        at_neg();
        chk("col_idle_busy", 32'(busy), 32'd0);
        chk("col_idle_avail", 32'(ssm_avail), 32'd0);
        chk("col_idle_ready", 32'(src_ready), 32'd0);
        cyc();
        at_neg();
        chk("col_start_dropped", 32'(busy), 32'd0);
        src_valid = 1'b0;
        cyc();

        // Underflow: pop substream 3 before its first word arrives.
        slice_start = 1'b1;
        cyc();
        slice_start = 1'b0;
        ssm_rd_en   = 4'b1000;
        cyc();
        ssm_rd_en = '0;
        at_neg();
        chk("uf_err", 32'(err_underflow), 32'h8);
        chk("uf_avail", 32'(ssm_avail), 32'd0);
        cyc();
        send(W'(128'hF0), 0, "uf_fill0", 0);
        send(W'(128'hF1), 1, "uf_fill1", 0);
        send(W'(128'hF2), 2, "uf_fill2", 0);
        send(W'(128'hF3), 3, "uf_fill3", 0);
        src_valid = 1'b0;
        at_neg();
        chk("uf_fill_avail", 32'(ssm_avail), 32'hF);
        chk("uf_sticky", 32'(err_underflow), 32'h8);
        cyc();
        slice_end = 1'b1;
        cyc();
        slice_end = 1'b0;
        exp_q.delete();
        cyc();
        at_neg();
        chk("uf_idle_busy", 32'(busy), 32'd0);
        chk("uf_idle_sticky", 32'(err_underflow), 32'h8);
        cyc();
        slice_start = 1'b1;
        cyc();
        slice_start = 1'b0;
        at_neg();
        chk("uf_cleared", 32'(err_underflow), 32'd0);
        chk("uf_restart_busy", 32'(busy), 32'd1);
        cyc();

        // Reset in the middle of the fill, then restart from substream 0.
        send(W'(128'h10), 0, "rs_g0", 0);
        send(W'(128'h11), 1, "rs_g1", 0);
        src_valid = 1'b0;
        rst       = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        at_neg();
        chk("rs_ready", 32'(src_ready), 32'd0);
        chk("rs_avail", 32'(ssm_avail), 32'd0);
        chk("rs_data_zero", 32'(ssm_data != '0), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_err", 32'(err_underflow), 32'd0);
        cyc();
        slice_start = 1'b1;
        cyc();
        slice_start = 1'b0;
        send(W'(128'h20), 0, "rs_h0", 0);
        src_valid = 1'b0;
        at_neg();
        chk("rs_refill_avail", 32'(ssm_avail), 32'h1);
        cyc();
        ssm_rd_en = 4'b0001;
        cyc();
        ssm_rd_en = '0;
        at_neg();
        chk("rs_drained_avail", 32'(ssm_avail), 32'd0);
        chk("rs_drained_err", 32'(err_underflow), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
